serial_logic_unit: RTL and testbench

Multi-cycle, handshaked evaluator for the 16-bit ALU bitwise operations: AND, OR, invert, XOR. It accepts a command (op, A, B) on a valid/ready input port, evaluates LANE bits per cycle LSB-first, and returns Y on a valid/ready output port. It sits between the lab sequencer/testbench driver and the result bus, and is the clocked, flow-controlled counterpart to the combinational bitwise units.

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_lane_eval.sv | 27 ++
 rtl/serial_logic_unit.sv | 110 +++++++++++
 tb/tb_serial_logic_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the serial bitwise logic unit: op encodings,
// FSM state type and the default operand width.
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_lane_eval.sv
// Combinational LANE-wide bitwise evaluator: applies one of the four
// logic ops to a slice of A and B.
module logic_lane_eval
    import logic_unit_pkg::*;
#(
    parameter int LANE = 1
) (
    input  logic [1:0]      op,
    input  logic [LANE-1:0] a_slice,
    input  logic [LANE-1:0] b_slice,
    output logic [LANE-1:0] y_slice
);

    // Select the bitwise function for the current slice.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves y_slice unassigned (no latch).
        y_slice = '0;
        unique case (op)
            OP_AND:  y_slice = a_slice & b_slice;
            OP_OR:   y_slice = a_slice | b_slice;
            OP_INV:  y_slice = ~a_slice;
            OP_XOR:  y_slice = a_slice ^ b_slice;
            default: y_slice = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle handshaked bitwise evaluator. A command is latched on the
// input handshake, evaluated LANE bits per cycle LSB-first, and the full
// result is presented on Y until the output handshake.
module serial_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    localparam int BEATS = WIDTH / LANE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [LANE-1:0]  w_y_slice;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;

    // Handshake status comes from the state register alone.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign Y         = r_y;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == LAST_BEAT);

    // The latched operands are shifted right each beat, so the current
    // slice is always at the bottom; the result slice enters at the top of
    // the accumulator and reaches bit 0 after the final beat.
    logic_lane_eval #(
        .LANE (LANE)
    ) u_lane_eval (
        .op      (r_op),
        .a_slice (r_a[LANE-1:0]),
        .b_slice (r_b[LANE-1:0]),
        .y_slice (w_y_slice)
    );

    assign w_acc_next = (r_acc >> LANE) | (WIDTH'(w_y_slice) << (WIDTH - LANE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept in IDLE, count beats in RUN, wait for the consumer in DONE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch the command, evaluate one slice per beat, publish Y on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_AND;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_y   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= A;
            r_b   <= B;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> LANE;
            r_b   <= r_b >> LANE;
            r_acc <= w_acc_next;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_y <= w_acc_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit: directed test-plan steps plus
// randomized commands checked against a whole-word bitwise reference model.
// A second instance is built with LANE=4.
module tb_serial_logic_unit;

    localparam int WIDTH  = 16;
    localparam int BEATS  = 16;
    localparam int BEATS4 = 4;

    logic             clk;
    logic             rst_n;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             busy;

    logic             in_valid4;
    logic             in_ready4;
    logic [1:0]       op4;
    logic [WIDTH-1:0] A4;
    logic [WIDTH-1:0] B4;
    logic             out_valid4;
    logic             out_ready4;
    logic [WIDTH-1:0] Y4;
    logic             busy4;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] prev_y;
    logic [WIDTH-1:0] prev_y4;

    serial_logic_unit #(.WIDTH(WIDTH), .LANE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy)
    );

    serial_logic_unit #(.WIDTH(WIDTH), .LANE(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .op        (op4),
        .A         (A4),
        .B         (B4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .Y         (Y4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word bitwise result for an op code.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command on the LANE=1 instance with full timing checks.
    // stall: cycles out_ready stays low after completion.
    // hold_valid: keep in_valid high (A=0) during RUN to probe that it is ignored.
    task automatic do_cmd(input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int stall, input bit hold_valid);
        logic [WIDTH-1:0] exp_y;
        exp_y = model(o, a, b);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        op        = o;
        A         = a;
        B         = b;
        out_ready = (stall == 0);
        @(negedge clk);                       // after edge 0: command accepted
        check("busy_run", busy, 1'b1);
        check("in_ready_run", in_ready, 1'b0);
        check("y_hold_run", Y, prev_y);
        in_valid = hold_valid;
        op       = 2'($urandom);
        A        = hold_valid ? 16'h0000 : 16'($urandom);
        B        = 16'($urandom);
        repeat (BEATS - 1) @(negedge clk);    // after edge BEATS-1
        check("out_valid_early", out_valid, 1'b0);
        check("y_hold_late_run", Y, prev_y);
        in_valid = 1'b0;
        @(negedge clk);                       // after edge BEATS
        check("out_valid_done", out_valid, 1'b1);
        check("y_done", Y, exp_y);
        check("in_ready_done", in_ready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_y", Y, exp_y);
            check("stall_busy", busy, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);                       // after the output handshake
        check("in_ready_after", in_ready, 1'b1);
        check("out_valid_after", out_valid, 1'b0);
        check("busy_after", busy, 1'b0);
        check("y_hold_idle", Y, exp_y);
        prev_y = exp_y;
    endtask

    // One command on the LANE=4 instance.
    task automatic do_cmd4(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] exp_y;
        exp_y = model(o, a, b);
        @(negedge clk);
        check("l4_in_ready_idle", in_ready4, 1'b1);
        in_valid4  = 1'b1;
        op4        = o;
        A4         = a;
        B4         = b;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("l4_busy_run", busy4, 1'b1);
        check("l4_y_hold_run", Y4, prev_y4);
        in_valid4 = 1'b0;
        A4        = 16'($urandom);
        B4        = 16'($urandom);
        repeat (BEATS4 - 1) @(negedge clk);
        check("l4_out_valid_early", out_valid4, 1'b0);
        @(negedge clk);
        check("l4_out_valid_done", out_valid4, 1'b1);
        check("l4_y_done", Y4, exp_y);
        @(negedge clk);
        check("l4_in_ready_after", in_ready4, 1'b1);
        check("l4_busy_after", busy4, 1'b0);
        prev_y4 = exp_y;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op         = 2'b00;
        A          = '0;
        B          = '0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        op4        = 2'b00;
        A4         = '0;
        B4         = '0;
        out_ready4 = 1'b1;
        prev_y     = '0;
        prev_y4    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_y", Y, 16'h0000);
        check("rst_l4_y", Y4, 16'h0000);
        rst_n = 1'b1;

        // Directed test-plan steps
        do_cmd(2'b00, 16'hF0F0, 16'hFF00, 0, 1'b0);   // AND  -> F000
        do_cmd(2'b01, 16'h1200, 16'h0034, 0, 1'b0);   // OR   -> 1234
        do_cmd(2'b11, 16'hAAAA, 16'hFFFF, 0, 1'b0);   // XOR  -> 5555
        do_cmd(2'b10, 16'h1234, 16'hFFFF, 0, 1'b1);   // INV  -> EDCB, busy input ignored
        check("inv_not_requeued", busy, 1'b0);
        do_cmd(2'b00, 16'hF0F0, 16'hFF00, 10, 1'b0);  // backpressure

        // Reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b11;
        A        = 16'h0F0F;
        B        = 16'h00FF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_busy", busy, 1'b1);
        check("midrun_y_prev", Y, 16'hF000);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_y", Y, 16'h0000);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        prev_y  = '0;
        prev_y4 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(2'b11, 16'h0F0F, 16'h00FF, 0, 1'b0);   // fresh command after abort

        // Randomized commands
        for (int n = 0; n < 20; n++) begin
            do_cmd(2'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        // LANE=4 instance
        do_cmd4(2'b01, 16'h00FF, 16'hFF00);           // OR -> FFFF after edge 4
        for (int n = 0; n < 6; n++) begin
            do_cmd4(2'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
